// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector: shift-register history compared
// against a latched pattern of programmable length, with a saturating match counter.
module seq_detector_param #(
  parameter int               PAT_W       = 8,
  parameter int               CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'('b101),
  parameter int               DEF_LEN     = 3,
  parameter bit               DEF_OVERLAP = 1'b1,
  localparam int              LEN_W       = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             count_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic [LEN_W-1:0] fill
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-1:0] pattern_q;
  logic [LEN_W-1:0] len_q;
  logic             overlap_q;
  logic [PAT_W-1:0] hist_q;
  logic [LEN_W-1:0] fill_q;
  logic             match_q;
  logic [CNT_W-1:0] count_q;

  logic             accept;
  logic             hit;
  logic             full_next;
  logic [PAT_W-1:0] hist_next;
  logic [PAT_W-1:0] len_mask;
  logic [LEN_W:0]   fill_inc;
  logic [LEN_W-1:0] fill_sat;
  logic [LEN_W-1:0] cfg_len_clamped;

  assign accept    = in_valid && !cfg_load;
  assign hist_next = {hist_q[PAT_W-2:0], in_bit};
  assign fill_inc  = {1'b0, fill_q} + (LEN_W + 1)'(1);
  assign full_next = (fill_inc >= {1'b0, len_q});
  assign fill_sat  = full_next ? len_q : fill_inc[LEN_W-1:0];

  // Only the low len bits of history and pattern take part in the compare.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  assign hit = accept && (len_q != '0) && full_next &&
               ((hist_next & len_mask) == (pattern_q & len_mask));

  assign cfg_len_clamped = (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      pattern_q <= DEF_PATTERN;
      len_q     <= LEN_W'(DEF_LEN);
      overlap_q <= DEF_OVERLAP;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
    end else if (cfg_load) begin
      pattern_q <= cfg_pattern;
      len_q     <= cfg_len_clamped;
      overlap_q <= cfg_overlap;
      fill_q    <= '0;
      match_q   <= 1'b0;
    end else begin
      match_q <= hit;
      if (accept) begin
        hist_q <= hist_next;
        // Non-overlap mode restarts the fill count; stale history is masked by fill.
        fill_q <= (hit && !overlap_q) ? '0 : fill_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      count_q <= '0;
    end else if (count_clr) begin
      count_q <= hit ? CNT_W'(1) : '0;
    end else if (hit && (count_q != CNT_MAX)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign match       = match_q;
  assign match_count = count_q;
  assign fill        = fill_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param (CNT_W=4 so counter saturation is reachable).
module tb_seq_detector_param;

  logic       clk;
  logic       areset_n;
  logic       in_valid;
  logic       in_bit;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       count_clr;
  logic       match;
  logic [3:0] match_count;
  logic [3:0] fill;

  int total = 0;
  int bad   = 0;

  seq_detector_param #(.PAT_W(8), .CNT_W(4)) dut (
    .clk         (clk),
    .areset_n    (areset_n),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .count_clr   (count_clr),
    .match       (match),
    .match_count (match_count),
    .fill        (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic step(input logic v, input logic b, input logic clr);
    @(negedge clk);
    cfg_load  = 1'b0;
    count_clr = clr;
    in_valid  = v;
    in_bit    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input string tag, input logic b, input logic exp_m);
    step(1'b1, b, 1'b0);
    chk(tag, match, exp_m);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 1'b0);
    chk(tag, match, 1'b0);
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                      input logic v, input logic b);
    @(negedge clk);
    cfg_load    = 1'b1;
    count_clr   = 1'b0;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    in_valid    = v;
    in_bit      = b;
    @(posedge clk);
    #1;
    chk("cfg_match", match, 1'b0);
    chk("cfg_fill", fill, 4'd0);
  endtask

  initial begin
    areset_n    = 1'b0;
    in_valid    = 1'b0;
    in_bit      = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = 8'h00;
    cfg_len     = 4'd0;
    cfg_overlap = 1'b0;
    count_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_match", match, 1'b0);
    chk("rst_count", match_count, 4'd0);
    chk("rst_fill", fill, 4'd0);
    @(negedge clk);
    areset_n = 1'b1;

    // Defaults (101, len 3, overlap): 1,0,1,0,1
    feed("t1_b1", 1'b1, 1'b0);
    feed("t1_b2", 1'b0, 1'b0);
    feed("t1_b3", 1'b1, 1'b1);
    feed("t1_b4", 1'b0, 1'b0);
    feed("t1_b5", 1'b1, 1'b1);
    chk("t1_count", match_count, 4'd2);
    chk("t1_fill", fill, 4'd3);
    idle("t1_idle");

    // Non-overlap 101: 1,0,1,0,1,0,1
    load(8'b101, 4'd3, 1'b0, 1'b0, 1'b0);
    chk("t2_cfg_count", match_count, 4'd2);
    feed("t2_b1", 1'b1, 1'b0);
    feed("t2_b2", 1'b0, 1'b0);
    feed("t2_b3", 1'b1, 1'b1);
    chk("t2_fill_rst", fill, 4'd0);
    feed("t2_b4", 1'b0, 1'b0);
    feed("t2_b5", 1'b1, 1'b0);
    feed("t2_b6", 1'b0, 1'b0);
    feed("t2_b7", 1'b1, 1'b1);
    chk("t2_count", match_count, 4'd4);

    // Idle gaps between pattern bits
    feed("t3_b1", 1'b1, 1'b0);
    idle("t3_gap1");
    feed("t3_b2", 1'b0, 1'b0);
    idle("t3_gap2a");
    idle("t3_gap2b");
    idle("t3_gap2c");
    chk("t3_fill_hold", fill, 4'd2);
    feed("t3_b3", 1'b1, 1'b1);
    idle("t3_no_stretch");
    chk("t3_count", match_count, 4'd5);

    // Saturation with "11" overlap: back-to-back pulses
    load(8'b11, 4'd2, 1'b1, 1'b0, 1'b0);
    feed("t4_first", 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) feed("t4_run", 1'b1, 1'b1);
    chk("t4_count15", match_count, 4'd15);
    feed("t4_extra", 1'b1, 1'b1);
    chk("t4_sat", match_count, 4'd15);
    step(1'b1, 1'b1, 1'b1);
    chk("t4_clr_hit_m", match, 1'b1);
    chk("t4_clr_hit_cnt", match_count, 4'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("t4_clr_cnt", match_count, 4'd0);
    chk("t4_clr_m", match, 1'b0);

    // cfg_load mid-pattern discards its bit and restarts fill
    load(8'b101, 4'd3, 1'b1, 1'b0, 1'b0);
    feed("t5_p1", 1'b1, 1'b0);
    feed("t5_p2", 1'b0, 1'b0);
    load(8'b101, 4'd3, 1'b1, 1'b1, 1'b1);
    feed("t5_r1", 1'b1, 1'b0);
    feed("t5_r2", 1'b0, 1'b0);
    feed("t5_r3", 1'b1, 1'b1);
    chk("t5_count1", match_count, 4'd1);

    // len 8, A5 MSB-first
    load(8'hA5, 4'd8, 1'b1, 1'b0, 1'b0);
    feed("t5_a7", 1'b1, 1'b0);
    feed("t5_a6", 1'b0, 1'b0);
    feed("t5_a5", 1'b1, 1'b0);
    feed("t5_a4", 1'b0, 1'b0);
    feed("t5_a3", 1'b0, 1'b0);
    feed("t5_a2", 1'b1, 1'b0);
    feed("t5_a1", 1'b0, 1'b0);
    feed("t5_a0", 1'b1, 1'b1);
    chk("t5_a_fill", fill, 4'd8);
    chk("t5_count2", match_count, 4'd2);

    // len 15 clamps to 8
    load(8'hA5, 4'd15, 1'b1, 1'b0, 1'b0);
    feed("t5_c7", 1'b1, 1'b0);
    feed("t5_c6", 1'b0, 1'b0);
    feed("t5_c5", 1'b1, 1'b0);
    feed("t5_c4", 1'b0, 1'b0);
    feed("t5_c3", 1'b0, 1'b0);
    feed("t5_c2", 1'b1, 1'b0);
    feed("t5_c1", 1'b0, 1'b0);
    feed("t5_c0", 1'b1, 1'b1);
    chk("t5_clamp_fill", fill, 4'd8);
    chk("t5_count3", match_count, 4'd3);

    // len 0 disables detection
    load(8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
    feed("t5_z1", 1'b1, 1'b0);
    feed("t5_z2", 1'b0, 1'b0);
    feed("t5_z3", 1'b1, 1'b0);
    feed("t5_z4", 1'b0, 1'b0);
    feed("t5_z5", 1'b1, 1'b0);
    chk("t5_z_fill", fill, 4'd0);
    chk("t5_z_count", match_count, 4'd3);

    // Async reset mid-stream, then defaults must be back in effect
    load(8'h0F, 4'd4, 1'b0, 1'b0, 1'b0);
    feed("t6_b1", 1'b1, 1'b0);
    feed("t6_b2", 1'b1, 1'b0);
    feed("t6_b3", 1'b1, 1'b0);
    feed("t6_b4", 1'b1, 1'b1);
    chk("t6_pre_count", match_count, 4'd4);
    #2;
    areset_n = 1'b0;
    #1;
    chk("t6_rst_match", match, 1'b0);
    chk("t6_rst_count", match_count, 4'd0);
    chk("t6_rst_fill", fill, 4'd0);
    @(negedge clk);
    areset_n = 1'b1;
    feed("t6_d1", 1'b1, 1'b0);
    feed("t6_d2", 1'b0, 1'b0);
    feed("t6_d3", 1'b1, 1'b1);
    feed("t6_d4", 1'b0, 1'b0);
    feed("t6_d5", 1'b1, 1'b1);
    chk("t6_fill", fill, 4'd3);
    chk("t6_count", match_count, 4'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
